regfile: RTL and testbench

// - Architectural integer register file (x0..x31) for the 5-stage RV32I pipeline.
// - Answers the decode stage's two read requests (read1_*/read2_*); accepts one write per cycle from write-back.
// - Keeps x0 hard-wired to zero and counts committed register writes for debug/perf.

---
 rtl/regfile.sv | 106 ++++++++++
 tb/tb_regfile.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/regfile.sv
// rtl/regfile.sv - RV32I architectural register file with write counter
//
// Purpose: holds x0..x(2**ADDR_W-1) for the pipeline. Two combinational read
// ports serve decode, one write port serves write-back. x0 always reads as
// zero and is never written. write_count tallies committed non-x0 writes.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   -> write-first: a same-cycle write to the read index is
//                returned on the read port in that cycle.
//   undefined -> read-old: a read returns the stored value; the new value is
//                visible from the cycle after the write edge.
//
// Ports:
//   clk            in   rising-edge clock
//   rst            in   synchronous reset, active-high
//   write_flag     in   write-back valid this cycle
//   write_address  in   destination register index (ADDR_W)
//   write_data     in   value to commit (DATA_W)
//   read1_flag     in   decode requests operand 1
//   read1_address  in   operand-1 register index (ADDR_W)
//   read1_data     out  operand-1 value, combinational (DATA_W)
//   read2_flag     in   decode requests operand 2
//   read2_address  in   operand-2 register index (ADDR_W)
//   read2_data     out  operand-2 value, combinational (DATA_W)
//   write_count    out  committed non-x0 writes since reset, wraps (CNT_W)

module regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write_flag,
  input  logic [ADDR_W-1:0] write_address,
  input  logic [DATA_W-1:0] write_data,
  input  logic              read1_flag,
  input  logic [ADDR_W-1:0] read1_address,
  output logic [DATA_W-1:0] read1_data,
  input  logic              read2_flag,
  input  logic [ADDR_W-1:0] read2_address,
  output logic [DATA_W-1:0] read2_data,
  output logic [CNT_W-1:0]  write_count
);

  localparam int NREG = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;

  // A write commits only to a non-zero index; x0 stays hard-wired to zero.
  logic write_en;
  assign write_en = write_flag && (write_address != '0);

  always_comb begin
    regs_d  = regs_q;
    count_d = count_q;
    if (write_en) begin
      regs_d[write_address] = write_data;
      count_d               = count_q + CNT_ONE;
    end
  end

  // Reset has priority over a simultaneous write, which is dropped uncounted.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      count_q <= '0;
    end else begin
      regs_q  <= regs_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    read1_data = '0;
    if (!rst && read1_flag && (read1_address != '0)) begin
      read1_data = regs_q[read1_address];
`ifdef REGFILE_BYPASS_EN
      if (write_en && (write_address == read1_address)) begin
        read1_data = write_data;
      end
`endif
    end
  end

  always_comb begin
    read2_data = '0;
    if (!rst && read2_flag && (read2_address != '0)) begin
      read2_data = regs_q[read2_address];
`ifdef REGFILE_BYPASS_EN
      if (write_en && (write_address == read2_address)) begin
        read2_data = write_data;
      end
`endif
    end
  end

  assign write_count = count_q;

endmodule

// File: tb/tb_regfile.sv
// tb/tb_regfile.sv - scoreboard bench for regfile against an array-based model

module tb_regfile;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              write_flag;
  logic [ADDR_W-1:0] write_address;
  logic [DATA_W-1:0] write_data;
  logic              read1_flag;
  logic [ADDR_W-1:0] read1_address;
  logic [DATA_W-1:0] read1_data;
  logic              read2_flag;
  logic [ADDR_W-1:0] read2_address;
  logic [DATA_W-1:0] read2_data;
  logic [CNT_W-1:0]  write_count;

  regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .write_flag    (write_flag),
    .write_address (write_address),
    .write_data    (write_data),
    .read1_flag    (read1_flag),
    .read1_address (read1_address),
    .read1_data    (read1_data),
    .read2_flag    (read2_flag),
    .read2_address (read2_address),
    .read2_data    (read2_data),
    .write_count   (write_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [3:0]  cnt;
  } exp_t;

  exp_t exp_q[$];

  int checks   = 0;
  int failures = 0;

  // Reference model: plain array of register contents plus a modulo-16 count.
  int unsigned model_mem [32];
  int unsigned model_cnt;

  function automatic int unsigned model_read(input bit r, input bit we, input int wa,
                                             input int unsigned wd, input bit f, input int a);
    if (r || !f || a == 0) return 0;
`ifdef REGFILE_BYPASS_EN
    if (we && wa == a) return wd;
`endif
    return model_mem[a];
  endfunction

  // One clock cycle of stimulus: drive after the edge, queue the expectation
  // seen before the next edge, then advance the model past that edge.
  task automatic cyc(input int tag, input bit r, input bit we, input int wa,
                     input int unsigned wd, input bit f1, input int a1,
                     input bit f2, input int a2, input bit chk);
    exp_t e;
    @(posedge clk);
    #1;
    rst           = r;
    write_flag    = we;
    write_address = ADDR_W'(wa);
    write_data    = wd;
    read1_flag    = f1;
    read1_address = ADDR_W'(a1);
    read2_flag    = f2;
    read2_address = ADDR_W'(a2);
    if (chk) begin
      e.tag = tag;
      e.r1  = model_read(r, we, wa, wd, f1, a1);
      e.r2  = model_read(r, we, wa, wd, f2, a2);
      e.cnt = 4'(model_cnt);
      exp_q.push_back(e);
    end
    if (r) begin
      for (int i = 0; i < 32; i++) model_mem[i] = 0;
      model_cnt = 0;
    end else if (we && wa != 0) begin
      model_mem[wa] = wd;
      model_cnt     = (model_cnt + 1) % 16;
    end
  endtask

  // Monitor: compares DUT outputs mid-cycle against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (read1_data !== e.r1) begin
          failures++;
          $display("FAIL read1 tag=%0d got=%h want=%h", e.tag, read1_data, e.r1);
        end
        checks++;
        if (read2_data !== e.r2) begin
          failures++;
          $display("FAIL read2 tag=%0d got=%h want=%h", e.tag, read2_data, e.r2);
        end
        checks++;
        if (write_count !== e.cnt) begin
          failures++;
          $display("FAIL write_count tag=%0d got=%0d want=%0d", e.tag, write_count, e.cnt);
        end
      end
    end
  end

  initial begin
    int wait_cycles;
    rst = 1'b1; write_flag = 1'b0; write_address = '0; write_data = '0;
    read1_flag = 1'b0; read1_address = '0; read2_flag = 1'b0; read2_address = '0;
    for (int i = 0; i < 32; i++) model_mem[i] = 0;
    model_cnt = 0;

    // T1: two reset cycles, then every register reads zero
    cyc(100, 1, 0, 0, 0, 1, 3, 1, 4, 0);
    cyc(101, 1, 1, 6, 32'h1111, 1, 6, 1, 6, 1);
    for (int i = 1; i < 32; i += 2) cyc(110 + i, 0, 0, 0, 0, 1, i, 1, (i + 1) % 32, 1);

    // T2: write x5, read it on both ports next cycle
    cyc(200, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 1);
    cyc(201, 0, 0, 0, 0, 1, 5, 1, 5, 1);

    // T3: x0 write ignored; flag low reads zero
    cyc(300, 0, 1, 0, 32'h12345678, 1, 0, 1, 0, 1);
    cyc(301, 0, 0, 0, 0, 1, 0, 0, 5, 1);

    // T4: same-cycle write/read hazard on x7
    cyc(400, 0, 1, 7, 32'h1, 0, 0, 0, 0, 1);
    cyc(401, 0, 1, 7, 32'hABCD, 1, 7, 1, 7, 1);
    cyc(402, 0, 0, 0, 0, 1, 7, 0, 0, 1);

    // T5: reset beats a write; reset after three writes clears them all
    cyc(500, 1, 1, 9, 32'h55, 1, 9, 1, 5, 1);
    cyc(501, 0, 0, 0, 0, 1, 9, 1, 5, 1);
    cyc(502, 0, 1, 1, 32'hA1, 0, 0, 0, 0, 1);
    cyc(503, 0, 1, 2, 32'hA2, 1, 1, 0, 0, 1);
    cyc(504, 0, 1, 3, 32'hA3, 1, 2, 1, 1, 1);
    cyc(505, 1, 0, 0, 0, 1, 3, 1, 2, 1);
    cyc(506, 0, 0, 0, 0, 1, 1, 1, 3, 1);

    // T6: 17 writes drive the 4-bit counter through 15 and back to 0
    for (int i = 0; i < 17; i++) cyc(600 + i, 0, 1, 1 + i % 31, 32'hC000 + i, 1, 1 + i % 31, 1, 1, 1);

    // Random traffic over a narrow index range to provoke hazards
    for (int i = 0; i < 400; i++) begin
      cyc(1000 + i, ($urandom_range(0, 39) == 0), $urandom_range(0, 1), $urandom_range(0, 7),
          $urandom, ($urandom_range(0, 3) != 0), $urandom_range(0, 7),
          ($urandom_range(0, 3) != 0), $urandom_range(0, 7), 1);
    end

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 20) begin
      @(posedge clk);
      wait_cycles++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
